// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory plus memory-mapped console TX
// FIFO and a free-running cycle counter, responding to a single-cycle core.
//
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   MemWrite          - one-cycle write strobe from the core
//   ALUResult         - byte address (bits [1:0] ignored)
//   WriteData         - store data
//   read_data         - combinational load data (pre-edge state)
//   cons_data         - console byte at FIFO head
//   cons_valid        - FIFO non-empty
//   cons_ready        - console sink accepts cons_data this cycle
//
// Map: ALUResult[31]=0 -> RAM (aliased); 0x8000_0000 CONS_TX (reads 0);
//      0x8000_0004 CONS_STATUS {count[7:4], overflow, empty, full};
//      0x8000_0008 CYCLE (read-only); other high addresses unmapped.
module dmem_responder #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] read_data,
  output logic [7:0]  cons_data,
  output logic        cons_valid,
  input  logic        cons_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [31:0] ADDR_TX     = 32'h8000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
  localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0008;

  logic [31:0]   ram_q  [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic [31:0]   cycle_q,  cycle_d;

  logic [31:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          sel_ram, sel_tx, sel_status, sel_cycle;
  logic          full, empty, pop, tx_wr, push, ovf_set;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^ALUResult[1:0];

  always_comb begin
    word_addr  = {ALUResult[31:2], 2'b00};
    ram_idx    = ALUResult[AW+1:2];
    sel_ram    = ~ALUResult[31];
    sel_tx     = (word_addr == ADDR_TX);
    sel_status = (word_addr == ADDR_STATUS);
    sel_cycle  = (word_addr == ADDR_CYCLE);
  end

  // A write to a full FIFO is still accepted when the head leaves in the
  // same cycle, so the slot freed by the pop is reused.
  always_comb begin
    full    = (count_q == CW'(FIFO_DEPTH));
    empty   = (count_q == '0);
    pop     = ~empty & cons_ready;
    tx_wr   = MemWrite & sel_tx;
    push    = tx_wr & (~full | pop);
    ovf_set = tx_wr & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set wins over clear if both land in one cycle.
    ovf_d = ovf_q;
    if (MemWrite && sel_status) ovf_d = 1'b0;
    if (ovf_set)                ovf_d = 1'b1;

    cycle_d = cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram) ram_q[ram_idx] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cycle_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cycle_q  <= cycle_d;
    end
  end

  always_comb begin
    read_data = '0;
    if (sel_ram) begin
      read_data = ram_q[ram_idx];
    end else if (sel_status) begin
      read_data[7:4] = 4'(count_q);
      read_data[2]   = ovf_q;
      read_data[1]   = empty;
      read_data[0]   = full;
    end else if (sel_cycle) begin
      read_data = cycle_q;
    end
  end

  assign cons_data  = fifo_q[rd_ptr_q];
  assign cons_valid = ~empty;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned RAM_WORDS  = 64;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam logic [31:0] A_TX     = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] read_data;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready;

  dmem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .read_data(read_data), .cons_data(cons_data),
    .cons_valid(cons_valid), .cons_ready(cons_ready)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] ram_m [int unsigned];
  logic [7:0]  q_m [$];
  bit          ovf_m;
  logic [31:0] cycle_m;
  bit          known;
  bit          dep_req = 1'b0;

  always @(posedge clk) begin
    int unsigned idx;
    bit          pop;
    idx = (ALUResult >> 2) % RAM_WORDS;
    if (MemWrite && !ALUResult[31]) ram_m[idx] = WriteData;
    if (reset) begin
      q_m.delete();
      ovf_m   = 1'b0;
      cycle_m = '0;
      known   = 1'b1;
    end else if (known) begin
      pop = (q_m.size() != 0) && cons_ready;
      if (pop) void'(q_m.pop_front());
      if (MemWrite && (ALUResult & ~32'd3) == A_STATUS) ovf_m = 1'b0;
      if (MemWrite && (ALUResult & ~32'd3) == A_TX) begin
        if (q_m.size() < FIFO_DEPTH) q_m.push_back(WriteData[7:0]);
        else ovf_m = 1'b1;
      end
      cycle_m = cycle_m + 32'd1;
    end
    if (dep_req) begin
      #1;
      dut.cycle_q = 32'hFFFF_FFFE;
      cycle_m     = 32'hFFFF_FFFE;
    end
  end

  // ---------------- single compare process ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          lit_en  = 1'b0;
  int          lit_sel;
  logic [31:0] lit_exp;
  string       lit_name;

  always @(negedge clk) begin
    logic [31:0] exp_rd;
    bit          rd_known;
    int unsigned n;
    if (known) begin
      n        = q_m.size();
      rd_known = 1'b1;
      exp_rd   = '0;
      if (!ALUResult[31]) begin
        if (ram_m.exists((ALUResult >> 2) % RAM_WORDS)) exp_rd = ram_m[(ALUResult >> 2) % RAM_WORDS];
        else rd_known = 1'b0;
      end else if ((ALUResult & ~32'd3) == A_STATUS) begin
        exp_rd = (n << 4) | (32'(ovf_m) << 2) | (32'(n == 0) << 1) | 32'(n == FIFO_DEPTH);
      end else if ((ALUResult & ~32'd3) == A_CYCLE) begin
        exp_rd = cycle_m;
      end
      if (rd_known) begin
        n_tests++;
        if (read_data !== exp_rd) begin
          n_fail++;
          $display("FAIL model_read_data addr=%h: got %h expected %h", ALUResult, read_data, exp_rd);
        end
      end
      n_tests++;
      if (cons_valid !== (n != 0)) begin
        n_fail++;
        $display("FAIL model_cons_valid: got %b expected %b", cons_valid, n != 0);
      end
      if (n != 0) begin
        n_tests++;
        if (cons_data !== q_m[0]) begin
          n_fail++;
          $display("FAIL model_cons_data: got %h expected %h", cons_data, q_m[0]);
        end
      end
    end
    if (lit_en) begin
      logic [31:0] act;
      case (lit_sel)
        0:       act = read_data;
        1:       act = {24'd0, cons_data};
        default: act = {31'd0, cons_valid};
      endcase
      n_tests++;
      if (act !== lit_exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", lit_name, act, lit_exp);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic lit(input int sel, input logic [31:0] exp, input string nm);
    lit_en = 1'b1; lit_sel = sel; lit_exp = exp; lit_name = nm;
    @(posedge clk); #1;
    lit_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    MemWrite = 1'b0; ALUResult = a;
    lit(0, exp, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; ALUResult = a; WriteData = d;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    MemWrite = 1'b0; ALUResult = 32'h0000_0010;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [7:0] ex [4];
    reset = 1'b1; MemWrite = 1'b0; ALUResult = '0; WriteData = '0; cons_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // reset state
    rd(A_CYCLE, 32'd0, "reset_cycle");
    lit(2, 32'd0, "reset_cons_valid");
    rd(A_STATUS, 32'h0000_0002, "reset_status");

    // RAM path and aliasing
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_read");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_read_low_bits");
    rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");
    wr(32'h0000_0020, 32'h1234_5678);
    rd(32'h0000_0020, 32'h1234_5678, "ram_read2");

    // unmapped, TX readback, CYCLE read-only
    rd(A_TX, 32'd0, "tx_reads_zero");
    rd(32'h8000_000C, 32'd0, "unmapped_read");
    wr(32'hFFFF_FFF0, 32'hFFFF_FFFF);
    wr(A_CYCLE, 32'h0000_1234);
    rd(A_STATUS, 32'h0000_0002, "status_after_unmapped_write");

    // fill and overflow
    for (int i = 0; i < 5; i++) wr(A_TX, 32'h41 + i);
    rd(A_STATUS, 32'h0000_0045, "status_full_ovf");
    lit(1, 32'h41, "head_after_fill");
    wr(A_STATUS, 32'd0);
    rd(A_STATUS, 32'h0000_0041, "status_ovf_cleared");

    // drain
    ALUResult = A_STATUS; cons_ready = 1'b1;
    for (int i = 0; i < 4; i++) lit(1, 32'h41 + i, "drain_byte");
    lit(2, 32'd0, "drained_valid");
    rd(A_STATUS, 32'h0000_0002, "drained_status");
    cons_ready = 1'b0;

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h11 + i);
    cons_ready = 1'b1;
    wr(A_TX, 32'h5A);
    cons_ready = 1'b0;
    rd(A_STATUS, 32'h0000_0041, "push_pop_full_status");
    ex[0] = 8'h12; ex[1] = 8'h13; ex[2] = 8'h14; ex[3] = 8'h5A;
    ALUResult = 32'h0000_0010; cons_ready = 1'b1;
    for (int i = 0; i < 4; i++) lit(1, 32'(ex[i]), "push_pop_order");
    lit(2, 32'd0, "push_pop_empty");
    cons_ready = 1'b0;

    // cycle counter and wrap
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    rd(A_CYCLE, 32'd0, "cycle_first");
    idle(4);
    rd(A_CYCLE, 32'd5, "cycle_after_5");
    dep_req = 1'b1;
    @(posedge clk); #2;
    dep_req = 1'b0;
    rd(A_CYCLE, 32'hFFFF_FFFE, "cycle_deposit");
    rd(A_CYCLE, 32'hFFFF_FFFF, "cycle_max");
    rd(A_CYCLE, 32'h0000_0000, "cycle_wrap");

    // reset mid-operation with a concurrent TX write
    for (int i = 0; i < 3; i++) wr(A_TX, 32'h61 + i);
    rd(A_STATUS, 32'h0000_0030, "three_queued");
    reset = 1'b1;
    wr(A_TX, 32'h77);
    reset = 1'b0;
    rd(A_CYCLE, 32'd0, "midreset_cycle");
    lit(2, 32'd0, "midreset_valid");
    rd(A_STATUS, 32'h0000_0002, "midreset_status");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "midreset_ram");

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
